// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, single-outstanding imem requests, decode FIFO
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc8
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          state_q;
   logic [31:0]     next_pc_q;
   logic [31:0]     req_addr_q;
   logic            drop_q;
   logic [31:0]     word_mem_q [FIFO_DEPTH];
   logic [31:0]     pc_mem_q   [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;

   logic [31:0]     redirect_tgt;
   logic            push;
   logic            pop;
   logic            has_space;

   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
   assign pop          = (count_q != '0) && inst_ready && !redirect_valid;
   assign push         = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;
   // The head being popped this cycle already counts as free space.
   assign has_space    = (count_q - CW'(pop)) < CW'(FIFO_DEPTH);
   assign count_d      = count_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         next_pc_q  <= RESET_PC;
         req_addr_q <= '0;
         drop_q     <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (redirect_valid) begin
                  state_q    <= S_REQ;
                  req_addr_q <= redirect_tgt;
               end else if (has_space) begin
                  state_q    <= S_REQ;
                  req_addr_q <= next_pc_q;
               end
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state_q <= S_WAIT;
                  // A pending or current redirect already owns next_pc.
                  if (!drop_q && !redirect_valid)
                     next_pc_q <= req_addr_q + 32'd4;
               end
            end
            S_WAIT: begin
               if (imem_rvalid)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         if (state_q == S_WAIT && imem_rvalid)
            drop_q <= 1'b0;
         else if (redirect_valid && state_q != S_IDLE)
            drop_q <= 1'b1;

         if (redirect_valid)
            next_pc_q <= redirect_tgt;

         if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push)
               wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         word_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]   <= req_addr_q;
      end
   end

   assign imem_req   = (state_q == S_REQ);
   assign imem_addr  = imem_req ? req_addr_q : '0;
   assign inst_valid = (count_q != '0);
   assign inst       = inst_valid ? word_mem_q[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign inst_pc8   = inst_valid ? pc_mem_q[rd_ptr_q] + 32'd8 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: memory model plus PC-stream scoreboard
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc8;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_pc8       (inst_pc8)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] grant_log[$];
   bit          outstanding, stale, req_seen, gnt_now, rand_mode;
   logic [31:0] out_addr, req_addr_seen, exp_pc;
   int          rv_left, gnt_cnt, gnt_lat, rv_lat, pops;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h2400_0001;
   endfunction

   function automatic logic [31:0] grant_at(input int idx);
      return (idx < grant_log.size()) ? grant_log[idx] : 32'hDEAD_BEEF;
   endfunction

   // One clock: drive memory responses, score the decode-visible stream, advance.
   task automatic tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      gnt_now     = 1'b0;
      if (outstanding) begin
         if (rv_left == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(out_addr);
            outstanding = 1'b0;
            stale       = 1'b0;
         end else begin
            rv_left--;
         end
      end
      if (!reset) begin
         exp_pc   = RESET_PC;
         req_seen = 1'b0;
         if (outstanding) stale = 1'b1;
      end else begin
         if (imem_req) begin
            if (!req_seen) begin
               req_seen      = 1'b1;
               req_addr_seen = imem_addr;
               gnt_cnt       = 0;
            end else begin
               check("addr_stable", imem_addr, req_addr_seen);
            end
            check("one_outstanding", 32'(outstanding && !stale), 32'd0);
            if (!outstanding && gnt_cnt >= gnt_lat) begin
               imem_gnt = 1'b1;
               gnt_now  = 1'b1;
               grant_log.push_back(imem_addr);
               outstanding = 1'b1;
               out_addr    = imem_addr;
               req_seen    = 1'b0;
               rv_left     = rand_mode ? int'($urandom_range(0, 3)) : rv_lat;
               if (rand_mode) gnt_lat = int'($urandom_range(0, 3));
            end else begin
               gnt_cnt++;
            end
         end
         if (!inst_valid) begin
            check("idle_inst", inst, 32'd0);
            check("idle_pc", inst_pc, 32'd0);
            check("idle_pc8", inst_pc8, 32'd0);
         end
         if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (inst_valid && inst_ready) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_inst", inst, word_of(exp_pc));
            check("pop_pc8", inst_pc8, exp_pc + 32'd8);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until_grants(input int n, input string tag);
      int budget = 80;
      while (grant_log.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      if (grant_log.size() < n) check({tag, "_timeout"}, 32'(grant_log.size()), 32'(n));
   endtask

   task automatic do_reset(input logic ready);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = ready;
      tick();
      tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
      check("rst_pc8", inst_pc8, 32'd0);
      grant_log.delete();
      reset = 1'b1;
   endtask

   initial begin
      int t;
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      outstanding = 0; stale = 0; req_seen = 0; gnt_now = 0; rand_mode = 0;
      out_addr = '0; req_addr_seen = '0; exp_pc = RESET_PC;
      rv_left = 0; gnt_cnt = 0; gnt_lat = 0; rv_lat = 0; pops = 0;
      @(negedge clk);

      // Reset release with an ideal memory: first word visible three cycles later.
      do_reset(1'b1);
      t = 0;
      while (!inst_valid && t < 10) begin tick(); t++; end
      check("t1_latency", 32'(t), 32'd3);
      check("t1_pc", inst_pc, 32'h3000);
      check("t1_pc8", inst_pc8, 32'h3008);
      run_until_grants(3, "t1");
      check("t1_g0", grant_at(0), 32'h3000);
      check("t1_g1", grant_at(1), 32'h3004);
      check("t1_g2", grant_at(2), 32'h3008);

      // Decode stalled: two grants fill the FIFO, then fetch stops.
      do_reset(1'b0);
      repeat (10) tick();
      check("t2_ngrants", 32'(grant_log.size()), 32'd2);
      check("t2_g0", grant_at(0), 32'h3000);
      check("t2_g1", grant_at(1), 32'h3004);
      check("t2_req_full", 32'(imem_req), 32'd0);
      check("t2_head", inst_pc, 32'h3000);
      inst_ready = 1'b1;
      run_until_grants(3, "t2");
      check("t2_resume", grant_at(2), 32'h3008);
      repeat (6) tick();

      // Redirect while waiting on 0x3008.
      do_reset(1'b1);
      rv_lat = 2;
      run_until_grants(3, "t3");
      check("t3_g2", grant_at(2), 32'h3008);
      redirect_valid = 1'b1; redirect_pc = 32'h3100;
      tick();
      redirect_valid = 1'b0;
      check("t3_flush", 32'(inst_valid), 32'd0);
      t = grant_log.size();
      run_until_grants(t + 1, "t3b");
      check("t3_target", grant_at(t), 32'h3100);
      repeat (8) tick();

      // Redirect during a REQ whose grant is held off.
      rv_lat = 0;
      do_reset(1'b1);
      run_until_grants(1, "t4");
      gnt_lat = 3;
      t = 0;
      while (!imem_req && t < 10) begin tick(); t++; end
      check("t4_req_addr", imem_addr, 32'h3004);
      redirect_valid = 1'b1; redirect_pc = 32'h3200;
      tick();
      redirect_valid = 1'b0;
      run_until_grants(3, "t4");
      check("t4_g1", grant_at(1), 32'h3004);
      check("t4_g2", grant_at(2), 32'h3200);
      gnt_lat = 0;
      repeat (8) tick();

      // Low bits masked and address wrap.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      grant_log.delete();
      run_until_grants(2, "t5");
      check("t5_g0", grant_at(0), 32'hFFFF_FFFC);
      check("t5_g1", grant_at(1), 32'h0000_0000);
      repeat (8) tick();

      // Reset in WAIT with a buffered entry; the stale response must not surface.
      do_reset(1'b0);
      rv_lat = 3;
      run_until_grants(2, "t6");
      check("t6_g1", grant_at(1), 32'h3004);
      reset = 1'b0;
      tick();
      check("t6_valid", 32'(inst_valid), 32'd0);
      check("t6_req", 32'(imem_req), 32'd0);
      reset = 1'b1;
      grant_log.delete();
      inst_ready = 1'b1;
      run_until_grants(1, "t6");
      check("t6_restart", grant_at(0), 32'h3000);
      repeat (10) tick();

      // Randomized latencies, stalls and redirects.
      rand_mode = 1'b1;
      pops = 0;
      repeat (3000) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom);
         end else begin
            redirect_valid = 1'b0;
         end
         tick();
      end
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      repeat (30) tick();
      check("rand_progress", 32'(pops > 100), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
